// File: rtl/regfile.sv
// Register file with x0 hardwired to zero and a post-reset clear sequencer.
// Optional write-first bypass: define REGFILE_BYPASS_EN.
module regfile #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic              we3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              clr;
  logic              wr;
  logic [WIDTH-1:0]  mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= ADDR_W'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter parks on the last index so the clear never runs a second pass.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = 1'b0;
    unique case (state)
      CLEAR: begin
        clr = 1'b1;
        if (cnt == LAST) state_nxt = READY;
        else             cnt_nxt   = cnt + 1'b1;
      end
      READY: begin
      end
    endcase
  end

  assign busy = (state == CLEAR);
  assign wr   = (state == READY) && we3 && (a3 != '0);

  // Storage carries no reset; the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr)     mem[cnt] <= '0;
    else if (wr) mem[a3]  <= wd3;
  end

  always_comb begin
    rd1 = '0;
    if (state == READY && a1 != '0) begin
      rd1 = mem[a1];
`ifdef REGFILE_BYPASS_EN
      if (wr && a3 == a1) rd1 = wd3;
`endif
    end
  end

  always_comb begin
    rd2 = '0;
    if (state == READY && a2 != '0) begin
      rd2 = mem[a2];
`ifdef REGFILE_BYPASS_EN
      if (wr && a3 == a2) rd2 = wd3;
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: clear sequence, x0, writes,
// read-during-write, reset restarts and randomized traffic vs a model.
module tb_regfile;
  localparam int W  = 8;
  localparam int N  = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] a1, a2, a3;
  logic [W-1:0]  wd3;
  logic          we3;
  logic [W-1:0]  rd1, rd2;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model [N];

  regfile #(.WIDTH(W), .NREGS(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .a1(a1), .a2(a2), .a3(a3),
    .wd3(wd3), .we3(we3),
    .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // Counts edges until busy falls, capped so a stuck DUT cannot hang.
  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    we3 = 1'b0; a1 = 5'd3; a2 = 5'd31; a3 = '0; wd3 = '0;
    #2;
    checks++;
    if (busy !== 1'b1 || rd1 !== 8'h00 || rd2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals busy=%b rd1=%h rd2=%h want 1 00 00",
               busy, rd1, rd2);
    end
    tick();
    reset = 1'b0;
    clear_model();
    wait_ready(n);
    checks++;
    if (n !== 31 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_len edges=%0d busy=%b want 31 0", n, busy);
    end
  endtask

  task automatic test_clear_zero;
    for (int a = 0; a < N; a++) begin
      a1 = AW'(a);
      a2 = AW'(N - 1 - a);
      #1;
      checks++;
      if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
        errors++;
        $display("FAIL clear_zero a=%0d rd1=%h rd2=%h want 00 00",
                 a, rd1, rd2);
      end
    end
  endtask

  task automatic test_write_read;
    a3 = 5'd5; wd3 = 8'h41; we3 = 1'b1;
    tick();
    we3 = 1'b0; model[5] = 8'h41;
    a1 = 5'd5; a2 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 8'h41 || rd2 !== 8'h41) begin
      errors++;
      $display("FAIL write5 rd1=%h rd2=%h want 41 41", rd1, rd2);
    end
    a3 = 5'd0; wd3 = 8'hFF; we3 = 1'b1; a1 = 5'd0; a2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
      errors++;
      $display("FAIL x0_bypass rd1=%h rd2=%h want 00 00", rd1, rd2);
    end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd2 !== 8'h00) begin
      errors++;
      $display("FAIL x0_write rd2=%h want 00", rd2);
    end
  endtask

  task automatic test_same_cycle;
    logic [W-1:0] exp;
    a3 = 5'd3; wd3 = 8'h0A; we3 = 1'b1; a1 = 5'd3; a2 = 5'd4;
    #1;
    exp = BYP ? 8'h0A : model[3];
    checks++;
    if (rd1 !== exp || rd2 !== model[4]) begin
      errors++;
      $display("FAIL rdw_pre rd1=%h rd2=%h want %h %h",
               rd1, rd2, exp, model[4]);
    end
    tick();
    we3 = 1'b0; model[3] = 8'h0A;
    #1;
    checks++;
    if (rd1 !== 8'h0A) begin
      errors++;
      $display("FAIL rdw_post rd1=%h want 0a", rd1);
    end
  endtask

  task automatic test_write_during_clear;
    int n;
    pulse_reset();
    we3 = 1'b1; a3 = 5'd7; wd3 = 8'h55; a1 = 5'd7; a2 = 5'd7;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (busy !== 1'b1 || rd1 !== 8'h00 || rd2 !== 8'h00) begin
        errors++;
        $display("FAIL clear_read i=%0d busy=%b rd1=%h rd2=%h want 1 00 00",
                 i, busy, rd1, rd2);
      end
      tick();
    end
    we3 = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("FAIL clear_rest edges=%0d want 11", n);
    end
    #1;
    checks++;
    if (rd1 !== 8'h00) begin
      errors++;
      $display("FAIL clear_we_ignored rd1=%h want 00", rd1);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    a3 = 5'd9; wd3 = 8'h33; we3 = 1'b1;
    tick();
    we3 = 1'b0; a1 = 5'd9;
    #1;
    checks++;
    if (rd1 !== 8'h33) begin
      errors++;
      $display("FAIL fill9 rd1=%h want 33", rd1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rd1 !== 8'h00) begin
      errors++;
      $display("FAIL async_reset busy=%b rd1=%h want 1 00", busy, rd1);
    end
    tick();
    reset = 1'b0;
    clear_model();
    wait_ready(n);
    checks++;
    if (n !== 31 || rd1 !== 8'h00) begin
      errors++;
      $display("FAIL reclear edges=%0d rd1=%h want 31 00", n, rd1);
    end
    pulse_reset();
    repeat (10) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midclear_busy busy=%b want 1", busy);
    end
    tick();
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL midclear_len edges=%0d want 31", n);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] e1, e2;
    for (int i = 0; i < 400; i++) begin
      a3  = AW'($urandom_range(0, N - 1));
      wd3 = W'($urandom);
      we3 = ($urandom_range(0, 3) != 0);
      a1  = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, N - 1));
      a2  = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, N - 1));
      #1;
      e1 = (a1 == 0) ? '0 : model[a1];
      e2 = (a2 == 0) ? '0 : model[a2];
      if (BYP && we3 && a3 != 0 && a3 == a1) e1 = wd3;
      if (BYP && we3 && a3 != 0 && a3 == a2) e2 = wd3;
      checks++;
      if (rd1 !== e1 || rd2 !== e2 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand i=%0d a1=%0d a2=%0d rd1=%h rd2=%h want %h %h",
                 i, a1, a2, rd1, rd2, e1, e2);
      end
      tick();
      if (we3 && a3 != 0) model[a3] = wd3;
    end
    we3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_write_read();
    test_same_cycle();
    test_random();
    test_write_during_clear();
    test_reset_mid();
    test_clear_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the single-cycle RISC-V datapath. It sits directly upstream of the ALU and drives its SrcA operand from `rd1` and its SrcB operand from `rd2`, or from the immediate mux. Register x0 is hardwired to zero. After reset, a hardware sequencer clears every register, so the core never reads stale storage.

## Interface
Parameters:
- `WIDTH`, 8: data width; matches the ALU operand width.
- `NREGS`, 32: number of architectural registers; must be a power of two and ≥ 2.
- `ADDR_W`, 5: address width; equals log2(`NREGS`).

Ports:
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `a1`  input  `ADDR_W`  read address, port 1 (rs1).
- `a2`  input  `ADDR_W`  read address, port 2 (rs2).
- `a3`  input  `ADDR_W`  write address (rd).
- `wd3`  input  `WIDTH`  write data, normally ALU result or memory read data.
- `we3`  input  1  write enable.
- `rd1`  output  `WIDTH`  read data, port 1; feeds ALU SrcA.
- `rd2`  output  `WIDTH`  read data, port 2; feeds ALU SrcB path.
- `busy`  output  1  high while the clear sequence runs; the core stalls its PC while it is high.

## Operation
- State machine with two states, CLEAR and READY, plus a clear counter `cnt` of width `ADDR_W`.
- `reset` high:
  - state forced to CLEAR and `cnt` forced to 1, asynchronously.
  - Storage array is not reset.
- CLEAR, each rising edge:
  - `reg[cnt]` <= 0 and `cnt` <= `cnt`+1.
  - If `cnt` == `NREGS`-1 at that edge, state <= READY; `cnt` does not wrap into a second pass.
- CLEAR, host side:
  - `we3` is ignored.
  - `rd1` and `rd2` read 0 regardless of address.
- READY, writes: on a rising edge with `we3`=1 and `a3`≠0, `reg[a3]` <= `wd3`. A write to `a3`=0 is discarded.
- READY, reads:
  - `rd1` = `reg[a1]` and `rd2` = `reg[a2]`, combinational.
  - Address 0 always reads 0.
- `busy` = (state == CLEAR). It is decoded from the state register, so it has no combinational path from any input.
- Reset asserted mid-clear or mid-operation: returns to CLEAR at `cnt`=1 and re-clears all registers; no partial state survives.
- Same-address reads: `a1`==`a2` is legal and both ports return the same value.

## Timing
- Reset values:
  - `busy`=1.
  - `rd1`=0 and `rd2`=0.
  - state=CLEAR, `cnt`=1.
- Clear latency: `busy` is high for exactly `NREGS`-1 rising edges after `reset` deasserts; 31 edges at defaults. It falls immediately after the edge that clears `reg[NREGS-1]`.
- Write latency: data written at edge N is visible on `rd1`/`rd2` after edge N, in the same cycle as the following instruction.
- Read latency: zero cycles; combinational from `a1`/`a2` to `rd1`/`rd2`.
- Read-during-write to the same address with bypass compiled out: the read port returns the old value until the write edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-first bypass.
  - In READY, if `we3`=1, `a3`≠0 and `a3`==`a1`, then `rd1`=`wd3` combinationally, before the edge.
  - Likewise for `rd2` when `a3`==`a2`.
  - Never applies during CLEAR or to x0.
- Undefined: no bypass; reads always return stored contents (read-before-write).

## Test plan
- Reset then release with defaults:
  - `busy` stays 1 for 31 edges, then 0.
  - Afterwards, reading all 32 addresses on both ports returns 0x00.
- READY write `a3`=5, `wd3`=0x41, `we3`=1:
  - After the edge, `a1`=5 gives `rd1`=0x41.
  - Write `a3`=0, `wd3`=0xFF; then `a2`=0 gives `rd2`=0x00.
- Write 0x0A to reg 3 while `a1`=3 in the same cycle:
  - Before the edge, `rd1`=old value (0x00) without the macro, or 0x0A with the macro.
  - After the edge, `rd1`=0x0A in both builds.
- Attempt write of 0x55 to reg 7 while `busy`=1:
  - `rd1` reads 0 during the clear.
  - After `busy` falls, reg 7 reads 0x00; the write was ignored.
- Reset mid-clear and mid-operation:
  - Fill reg 9 with 0x33, then assert `reset` for one cycle: `busy`=1 again for 31 edges, then reg 9 reads 0x00.
  - Assert `reset` again 10 edges into the clear: full 31-edge sequence restarts.
